// File: rtl/ifu_fetch_unit.sv
// ifu_fetch_unit: PC owner, imem req/ack fetcher and 2-entry prefetch buffer feeding decode
module ifu_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_ready,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] pc_ab,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        instr_misalign
);
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] h_addr_q, h_addr_d, h_data_q, h_data_d, t_addr_q, t_addr_d, t_data_q, t_data_d;
  logic        h_mis_q, h_mis_d, t_mis_q, t_mis_d;
  logic        req_q, req_d, drop_q, drop_d, halted_q, halted_d, valid_q, valid_d;
  logic [31:0] addr_q, addr_d, fetch_pc_q, fetch_pc_d, pc_n;
  logic        acc, redir, pop, ack_ok, push, mis, issue;
  // Buffer pop/push/flush, drop tracking and the next fetch decision
  always_comb begin
    acc = valid_q & instr_ready & (pc_sel != 2'b00);
    redir = acc & (pc_sel == 2'b10);
    pop = acc & ~redir;
    ack_ok = imem_ack & req_q;
    push = ack_ok & ~drop_q & ~redir;
    mis = |pc_ab[1:0];
    cnt_d = cnt_q;
    h_addr_d = h_addr_q;
    h_data_d = h_data_q;
    h_mis_d = h_mis_q;
    t_addr_d = t_addr_q;
    t_data_d = t_data_q;
    t_mis_d = t_mis_q;
    if (pop) begin
      if (cnt_q == 2'd2) begin
        h_addr_d = t_addr_q;
        h_data_d = t_data_q;
        h_mis_d = t_mis_q;
      end
      cnt_d = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) begin
        h_addr_d = addr_q;
        h_data_d = imem_rdata;
        h_mis_d = 1'b0;
      end else begin
        t_addr_d = addr_q;
        t_data_d = imem_rdata;
        t_mis_d = 1'b0;
      end
      cnt_d = cnt_d + 2'd1;
    end
    if (redir) begin
      cnt_d = {1'b0, mis};
      if (mis) begin
        h_addr_d = pc_ab;
        h_data_d = NOP_INSTR;
        h_mis_d = 1'b1;
      end
    end
    drop_d = (redir & req_q & ~ack_ok) | (drop_q & ~ack_ok);
    halted_d = redir ? mis : halted_q;
    pc_n = redir ? pc_ab : fetch_pc_q;
    issue = (~req_q | ack_ok) & ~halted_d & (cnt_d < 2'd2);
    req_d = issue | (req_q & ~ack_ok);
    addr_d = issue ? pc_n : addr_q;
    fetch_pc_d = issue ? pc_n + 32'd4 : pc_n;
    valid_d = cnt_d != 2'd0;
  end
  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      h_addr_q <= '0;
      h_data_q <= '0;
      h_mis_q <= 1'b0;
      t_addr_q <= '0;
      t_data_q <= '0;
      t_mis_q <= 1'b0;
      req_q <= 1'b0;
      drop_q <= 1'b0;
      halted_q <= 1'b0;
      valid_q <= 1'b0;
      addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      cnt_q <= cnt_d;
      h_addr_q <= h_addr_d;
      h_data_q <= h_data_d;
      h_mis_q <= h_mis_d;
      t_addr_q <= t_addr_d;
      t_data_q <= t_data_d;
      t_mis_q <= t_mis_d;
      req_q <= req_d;
      drop_q <= drop_d;
      halted_q <= halted_d;
      valid_q <= valid_d;
      addr_q <= addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end
  assign imem_req = req_q;
  assign imem_addr = addr_q;
  assign instr_valid = valid_q;
  assign instr = h_data_q;
  assign pc_out = h_addr_q;
  assign instr_misalign = h_mis_q;
endmodule

// File: tb/tb_ifu_fetch_unit.sv
// tb_ifu_fetch_unit: directed checks of fetch, buffering, redirect, misalign halt and PC wrap
module tb_ifu_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, instr_ready = 1'b0, imem_ack = 1'b0;
  logic [1:0] pc_sel = 2'b00;
  logic [31:0] pc_ab = '0, imem_rdata = '0;
  logic imem_req, instr_valid, instr_misalign, w_req, w_valid, w_mis;
  logic [31:0] imem_addr, instr, pc_out, w_addr, w_instr, w_pc;
  int n = 0, errs = 0;

  always #5 clk = ~clk;

  ifu_fetch_unit dut (
    .clk(clk), .rst(rst), .instr_ready(instr_ready), .pc_sel(pc_sel), .pc_ab(pc_ab),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out), .instr_misalign(instr_misalign)
  );

  ifu_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .instr_ready(instr_ready), .pc_sel(pc_sel), .pc_ab(pc_ab),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(w_valid), .instr(w_instr), .pc_out(w_pc), .instr_misalign(w_mis)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; pc_sel = 2'b00;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_req got=%h exp=0", imem_req); end
    n++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    n++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got=%h exp=0", instr_valid); end
    n++; if (instr !== 32'h0 || pc_out !== 32'h0) begin errs++; $display("FAIL rst_instr_pc got=%h/%h exp=0/0", instr, pc_out); end
    n++; if (instr_misalign !== 1'b0) begin errs++; $display("FAIL rst_mis got=%h exp=0", instr_misalign); end
    n++; if (w_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL rst_waddr got=%h exp=fffffffc", w_addr); end
  endtask

  task automatic test_sequential();
    instr_ready = 1'b1; pc_sel = 2'b01;
    tick();
    n++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errs++; $display("FAIL seq_req0 got=%h/%h exp=1/0", imem_req, imem_addr); end
    tick();
    n++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL seq_nov got=%h exp=0", instr_valid); end
    imem_ack = 1'b1; imem_rdata = mem(32'h0);
    tick(); imem_ack = 1'b0;
    n++; if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr !== mem(32'h0)) begin errs++; $display("FAIL seq_v0 got=%h/%h/%h exp=1/0/%h", instr_valid, pc_out, instr, mem(32'h0)); end
    n++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errs++; $display("FAIL seq_req4 got=%h/%h exp=1/4", imem_req, imem_addr); end
    tick();
    n++; if (instr_valid !== 1'b0 || imem_addr !== 32'h4) begin errs++; $display("FAIL seq_pop got=%h/%h exp=0/4", instr_valid, imem_addr); end
    imem_ack = 1'b1; imem_rdata = mem(32'h4);
    tick(); imem_ack = 1'b0;
    n++; if (pc_out !== 32'h4 || instr !== mem(32'h4) || imem_addr !== 32'h8) begin errs++; $display("FAIL seq_v4 got=%h/%h/%h exp=4/%h/8", pc_out, instr, imem_addr, mem(32'h4)); end
    tick();
    imem_ack = 1'b1; imem_rdata = mem(32'h8);
    tick(); imem_ack = 1'b0;
    n++; if (instr_valid !== 1'b1 || pc_out !== 32'h8 || imem_addr !== 32'hC) begin errs++; $display("FAIL seq_v8 got=%h/%h/%h exp=1/8/c", instr_valid, pc_out, imem_addr); end
  endtask

  task automatic test_full_and_redirect();
    do_reset();
    tick();
    n++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errs++; $display("FAIL full_req0 got=%h/%h exp=1/0", imem_req, imem_addr); end
    tick(); tick();
    imem_ack = 1'b1; imem_rdata = mem(32'h0);
    tick(); imem_ack = 1'b0;
    n++; if (instr_valid !== 1'b1 || imem_addr !== 32'h4) begin errs++; $display("FAIL full_req4 got=%h/%h exp=1/4", instr_valid, imem_addr); end
    tick(); tick();
    imem_ack = 1'b1; imem_rdata = mem(32'h4);
    tick(); imem_ack = 1'b0;
    n++; if (imem_req !== 1'b0 || pc_out !== 32'h0) begin errs++; $display("FAIL full_noreq got=%h/%h exp=0/0", imem_req, pc_out); end
    tick(); tick();
    n++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin errs++; $display("FAIL full_hold got=%h/%h exp=0/1", imem_req, instr_valid); end
    instr_ready = 1'b1; pc_sel = 2'b00;
    tick();
    n++; if (pc_out !== 32'h0 || imem_req !== 1'b0) begin errs++; $display("FAIL sel00_hold got=%h/%h exp=0/0", pc_out, imem_req); end
    pc_sel = 2'b01;
    tick(); instr_ready = 1'b0;
    n++; if (pc_out !== 32'h4 || instr !== mem(32'h4) || imem_req !== 1'b1 || imem_addr !== 32'h8) begin errs++; $display("FAIL full_pop got=%h/%h/%h/%h exp=4/%h/1/8", pc_out, instr, imem_req, imem_addr, mem(32'h4)); end
    instr_ready = 1'b1; pc_sel = 2'b10; pc_ab = 32'h100;
    tick(); instr_ready = 1'b0; pc_sel = 2'b00;
    n++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin errs++; $display("FAIL redir_flush got=%h/%h/%h exp=0/1/8", instr_valid, imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = mem(32'h8);
    tick(); imem_ack = 1'b0;
    n++; if (instr_valid !== 1'b0 || imem_addr !== 32'h100) begin errs++; $display("FAIL redir_drop got=%h/%h exp=0/100", instr_valid, imem_addr); end
    tick();
    imem_ack = 1'b1; imem_rdata = mem(32'h100);
    tick(); imem_ack = 1'b0;
    n++; if (instr_valid !== 1'b1 || pc_out !== 32'h100 || instr !== mem(32'h100) || imem_addr !== 32'h104) begin errs++; $display("FAIL redir_v100 got=%h/%h/%h/%h exp=1/100/%h/104", instr_valid, pc_out, instr, imem_addr, mem(32'h100)); end
  endtask

  task automatic test_redirect_same_ack();
    tick();
    imem_ack = 1'b1; imem_rdata = mem(32'h104);
    instr_ready = 1'b1; pc_sel = 2'b10; pc_ab = 32'h300;
    tick(); imem_ack = 1'b0; instr_ready = 1'b0; pc_sel = 2'b00;
    n++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin errs++; $display("FAIL same_ack got=%h/%h/%h exp=0/1/300", instr_valid, imem_req, imem_addr); end
    tick();
    imem_ack = 1'b1; imem_rdata = mem(32'h300);
    tick(); imem_ack = 1'b0;
    n++; if (instr_valid !== 1'b1 || pc_out !== 32'h300 || instr !== mem(32'h300)) begin errs++; $display("FAIL same_ack_v got=%h/%h/%h exp=1/300/%h", instr_valid, pc_out, instr, mem(32'h300)); end
  endtask

  task automatic test_misalign();
    do_reset();
    tick();
    imem_ack = 1'b1; imem_rdata = mem(32'h0);
    tick(); imem_rdata = mem(32'h4);
    tick(); imem_ack = 1'b0;
    n++; if (imem_req !== 1'b0 || pc_out !== 32'h0) begin errs++; $display("FAIL mis_full got=%h/%h exp=0/0", imem_req, pc_out); end
    instr_ready = 1'b1; pc_sel = 2'b10; pc_ab = 32'h102;
    tick(); pc_sel = 2'b00;
    n++; if (instr_valid !== 1'b1 || instr !== 32'h13 || pc_out !== 32'h102 || instr_misalign !== 1'b1) begin errs++; $display("FAIL mis_marker got=%h/%h/%h/%h exp=1/13/102/1", instr_valid, instr, pc_out, instr_misalign); end
    n++; if (imem_req !== 1'b0) begin errs++; $display("FAIL mis_noreq got=%h exp=0", imem_req); end
    tick(); tick();
    n++; if (imem_req !== 1'b0 || pc_out !== 32'h102) begin errs++; $display("FAIL mis_halt got=%h/%h exp=0/102", imem_req, pc_out); end
    pc_sel = 2'b10; pc_ab = 32'h200;
    tick(); instr_ready = 1'b0; pc_sel = 2'b00;
    n++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin errs++; $display("FAIL mis_release got=%h/%h/%h exp=0/1/200", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    tick();
    n++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_req0 got=%h/%h exp=1/fffffffc", w_req, w_addr); end
    imem_ack = 1'b1; imem_rdata = mem(32'hFFFF_FFFC);
    tick(); imem_ack = 1'b0;
    n++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_req !== 1'b1 || w_addr !== 32'h0) begin errs++; $display("FAIL wrap_next got=%h/%h/%h/%h exp=1/fffffffc/1/0", w_valid, w_pc, w_req, w_addr); end
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = mem(32'h0);
    tick();
    n++; if (w_req !== 1'b0 || w_valid !== 1'b0) begin errs++; $display("FAIL wrap_rst got=%h/%h exp=0/0", w_req, w_valid); end
    rst = 1'b0;
    tick(); imem_ack = 1'b0;
    n++; if (w_valid !== 1'b0 || w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_late_ack got=%h/%h/%h exp=0/1/fffffffc", w_valid, w_req, w_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full_and_redirect();
    test_redirect_same_ack();
    test_misalign();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
    $finish;
  end
endmodule
